// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter slice.
//   - default address width / increment
//   - next-PC source selector
//   - prio_enc: index of the lowest set bit (0 when nothing is set)
package pc_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_INSTR_BYTES = 4;
    localparam int MAX_REDIR       = 32;
    localparam int REDIR_IDX_W     = 5;

    typedef enum logic [2:0] {
        SRC_SEQ   = 3'd0,
        SRC_REDIR = 3'd1,
        SRC_PEND  = 3'd2,
        SRC_RET   = 3'd3,
        SRC_CALL  = 3'd4
    } next_src_e;

    // Channel 0 has the highest priority, so scan downwards and keep the last hit.
    function automatic logic [REDIR_IDX_W-1:0] prio_enc(input logic [MAX_REDIR-1:0] valid);
        logic [REDIR_IDX_W-1:0] idx;
        idx = {REDIR_IDX_W{1'b0}};
        for (int i = MAX_REDIR - 1; i >= 0; i--) begin
            if (valid[i]) begin
                idx = REDIR_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Request bundle driven into the PC unit by the rest of the fetch stage.
//   master : producer of stall / redirect / call / return requests
//   slave  : pc_fetch_ctrl
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_REDIR = 3
);
    logic                        PCWrite;
    logic [NUM_REDIR-1:0]        redirect_valid;
    logic [NUM_REDIR*ADDR_W-1:0] redirect_addr;
    logic                        call_valid;
    logic [ADDR_W-1:0]           call_target;
    logic                        ret_valid;

    modport master (
        output PCWrite, redirect_valid, redirect_addr,
        output call_valid, call_target, ret_valid
    );

    modport slave (
        input PCWrite, redirect_valid, redirect_addr,
        input call_valid, call_target, ret_valid
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry (count saturates at RAS_DEPTH). Operations are mutually exclusive,
// priority push > pop > replace_top. State updates on the falling clock edge.
// Ports: CLK, Reset (sync, active high), push/pop/replace_top + push_data,
//        top (current top entry), count, full, empty.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace_top,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  nxt_ptr_s;
    logic [PTR_W-1:0]  prv_ptr_s;

    assign nxt_ptr_s = top_ptr_r + PTR_W'(1);
    assign prv_ptr_s = top_ptr_r - PTR_W'(1);
    assign full      = (count_r == CNT_W'(RAS_DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign top       = mem_r[top_ptr_r];
    assign count     = count_r;

    // Stack storage, top pointer and occupancy.
    always_ff @(negedge CLK) begin
        if (Reset) begin
            top_ptr_r <= PTR_W'(0);
            count_r   <= CNT_W'(0);
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= ADDR_W'(0);
            end
        end else if (push) begin
            mem_r[nxt_ptr_s] <= push_data;
            top_ptr_r        <= nxt_ptr_s;
            if (!full) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                top_ptr_r <= prv_ptr_s;
                count_r   <= count_r - CNT_W'(1);
            end
        end else if (replace_top) begin
            mem_r[top_ptr_r] <= push_data;
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: sequential increment, prioritised redirects,
// redirects captured during a stall, and call/return via pc_ras.
// All state changes on the falling edge of CLK.
// Ports: CLK, Reset (sync, active high), bus (pc_fetch_ctrl_if.slave requests),
//        currentAddress, redirect_pending, ras_count, ras_overflow (sticky),
//        ras_underflow (sticky).
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int NUM_REDIR    = 3,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    pc_fetch_ctrl_if.slave             bus,
    output logic [ADDR_W-1:0]          currentAddress,
    output logic                       redirect_pending,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);
    logic [ADDR_W-1:0]      pc_r;
    logic                   pend_r;
    logic [ADDR_W-1:0]      pend_addr_r;
    logic                   ovf_r;
    logic                   unf_r;

    logic [ADDR_W-1:0]      seq_s;
    logic                   live_any_s;
    logic [REDIR_IDX_W-1:0] live_idx_s;
    logic [ADDR_W-1:0]      live_addr_s;
    next_src_e              src_s;
    logic [ADDR_W-1:0]      next_pc_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   replace_s;
    logic                   set_ovf_s;
    logic                   set_unf_s;
    logic [ADDR_W-1:0]      ras_top_s;
    logic                   ras_full_s;
    logic                   ras_empty_s;

    assign seq_s       = pc_r + ADDR_W'(INSTR_BYTES);
    assign live_any_s  = |bus.redirect_valid;
    assign live_idx_s  = prio_enc(MAX_REDIR'(bus.redirect_valid));
    assign live_addr_s = bus.redirect_addr[int'(live_idx_s) * ADDR_W +: ADDR_W];

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK         (CLK),
        .Reset       (Reset),
        .push        (push_s),
        .pop         (pop_s),
        .replace_top (replace_s),
        .push_data   (seq_s),
        .top         (ras_top_s),
        .count       (ras_count),
        .full        (ras_full_s),
        .empty       (ras_empty_s)
    );

    // Next-PC source selection and RAS operation decode.
    always_comb begin
        src_s     = SRC_SEQ;
        next_pc_s = seq_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        replace_s = 1'b0;
        set_ovf_s = 1'b0;
        set_unf_s = 1'b0;
        if (bus.PCWrite) begin
            if (live_any_s) begin
                src_s = SRC_REDIR;
            end else if (pend_r) begin
                src_s = SRC_PEND;
            end else if (bus.ret_valid) begin
                src_s = SRC_RET;
            end else if (bus.call_valid) begin
                src_s = SRC_CALL;
            end else begin
                src_s = SRC_SEQ;
            end
        end else begin
            src_s = SRC_SEQ;
        end
        case (src_s)
            SRC_REDIR: next_pc_s = live_addr_s;
            SRC_PEND:  next_pc_s = pend_addr_r;
            SRC_RET: begin
                // A simultaneous call turns the pop into a replace (or a push when empty).
                if (ras_empty_s) begin
                    next_pc_s = seq_s;
                    set_unf_s = 1'b1;
                    push_s    = bus.call_valid;
                end else begin
                    next_pc_s = ras_top_s;
                    replace_s = bus.call_valid;
                    pop_s     = !bus.call_valid;
                end
            end
            SRC_CALL: begin
                next_pc_s = bus.call_target;
                push_s    = 1'b1;
                set_ovf_s = ras_full_s;
            end
            SRC_SEQ:  next_pc_s = seq_s;
            default:  next_pc_s = seq_s;
        endcase
    end

    // PC, captured-redirect and sticky-flag registers.
    always_ff @(negedge CLK) begin
        if (Reset) begin
            pc_r        <= RESET_VECTOR;
            pend_r      <= 1'b0;
            pend_addr_r <= ADDR_W'(0);
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else if (bus.PCWrite) begin
            // Any advancing edge consumes whatever redirect was held.
            pc_r   <= next_pc_s;
            pend_r <= 1'b0;
            ovf_r  <= ovf_r | set_ovf_s;
            unf_r  <= unf_r | set_unf_s;
        end else if (live_any_s) begin
            pend_r      <= 1'b1;
            pend_addr_r <= live_addr_s;
        end
    end

    assign currentAddress   = pc_r;
    assign redirect_pending = pend_r;
    assign ras_overflow     = ovf_r;
    assign ras_underflow    = unf_r;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        pcw;
        logic [2:0]  rv;
        logic [31:0] a0, a1, a2;
        logic        call;
        logic [31:0] ct;
        logic        ret;
        logic [31:0] epc;
        logic        epend;
        logic [2:0]  ecnt;
        logic        eovf;
        logic        eunf;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset;
    logic Reset8;
    always #5 CLK = ~CLK;

    pc_fetch_ctrl_if #(.ADDR_W(32), .NUM_REDIR(3)) bus ();
    pc_fetch_ctrl_if #(.ADDR_W(8),  .NUM_REDIR(3)) bus8 ();

    logic [31:0] cur_addr;
    logic        pend;
    logic [2:0]  cnt;
    logic        ovf, unf;
    logic [7:0]  cur_addr8;
    logic        pend8, ovf8, unf8;
    logic [2:0]  cnt8;

    pc_fetch_ctrl #(.ADDR_W(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0),
                    .NUM_REDIR(3), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus), .currentAddress(cur_addr),
        .redirect_pending(pend), .ras_count(cnt), .ras_overflow(ovf),
        .ras_underflow(unf));

    pc_fetch_ctrl #(.ADDR_W(8), .INSTR_BYTES(4), .RESET_VECTOR(8'h0),
                    .NUM_REDIR(3), .RAS_DEPTH(4)) dut8 (
        .CLK(CLK), .Reset(Reset8), .bus(bus8), .currentAddress(cur_addr8),
        .redirect_pending(pend8), .ras_count(cnt8), .ras_overflow(ovf8),
        .ras_underflow(unf8));

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic pcw, input logic [2:0] rv,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                                input logic call, input logic [31:0] ct, input logic ret,
                                input logic [31:0] epc, input logic epend, input logic [2:0] ecnt,
                                input logic eovf, input logic eunf);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.rv = rv; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.call = call; v.ct = ct; v.ret = ret;
        v.epc = epc; v.epend = epend; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
        return v;
    endfunction

    // Drive one vector after the rising edge, let the DUT update on the falling
    // edge, then pop the scoreboard and compare shortly after.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(posedge CLK);
        Reset              = v.rst;
        bus.PCWrite        = v.pcw;
        bus.redirect_valid = v.rv;
        bus.redirect_addr  = {v.a2, v.a1, v.a0};
        bus.call_valid     = v.call;
        bus.call_target    = v.ct;
        bus.ret_valid      = v.ret;
        e.pc = v.epc; e.pend = v.epend; e.cnt = v.ecnt; e.ovf = v.eovf; e.unf = v.eunf;
        exp_q.push_back(e);
        @(negedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty vec=%0d got none expected entry", idx);
        end else begin
            got = exp_q.pop_front();
            chk($sformatf("pc[%0d]", idx),   cur_addr,     got.pc);
            chk($sformatf("pend[%0d]", idx), 32'(pend),    32'(got.pend));
            chk($sformatf("cnt[%0d]", idx),  32'(cnt),     32'(got.cnt));
            chk($sformatf("ovf[%0d]", idx),  32'(ovf),     32'(got.ovf));
            chk($sformatf("unf[%0d]", idx),  32'(unf),     32'(got.unf));
        end
    endtask

    task automatic step8(input logic rst, input logic pcw, input logic [2:0] rv,
                         input logic [7:0] a0, input logic [7:0] epc, input string name);
        @(posedge CLK);
        Reset8              = rst;
        bus8.PCWrite        = pcw;
        bus8.redirect_valid = rv;
        bus8.redirect_addr  = {8'h00, 8'h00, a0};
        bus8.call_valid     = 1'b0;
        bus8.call_target    = 8'h00;
        bus8.ret_valid      = 1'b0;
        @(negedge CLK);
        #1;
        chk(name, 32'(cur_addr8), 32'(epc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Reset8 = 1'b1;
        bus.PCWrite = 1'b0; bus.redirect_valid = 3'b000; bus.redirect_addr = '0;
        bus.call_valid = 1'b0; bus.call_target = 32'h0; bus.ret_valid = 1'b0;
        bus8.PCWrite = 1'b0; bus8.redirect_valid = 3'b000; bus8.redirect_addr = '0;
        bus8.call_valid = 1'b0; bus8.call_target = 8'h0; bus8.ret_valid = 1'b0;

        //           rst  pcw  rv      a0      a1      a2      call ct      ret   pc     pend cnt ovf unf
        // reset and sequential advance
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'h4,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'h8,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'hC,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'h10,  0, 0, 0, 0));
        // redirect priority
        vecs.push_back(mk(0, 1, 3'b110, 0, 32'h200, 32'h300, 0, 0, 0, 32'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b111, 32'h100, 32'h200, 32'h300, 0, 0, 0, 32'h100, 0, 0, 0, 0));
        // redirects captured during stall, newer one wins
        vecs.push_back(mk(0, 0, 3'b100, 0, 0, 32'h300, 0, 0, 0, 32'h100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b010, 0, 32'h200, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0, 0));
        // call ignored during stall; redirect beats call
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 1, 32'h999, 0, 32'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0, 0, 0, 1, 32'h500, 0, 32'h0, 0, 0, 0, 0));
        // five calls into a 4-deep stack, then five returns
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h40,  0, 32'h40,  0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h80,  0, 32'h80,  0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'hC0,  0, 32'hC0,  0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h100, 0, 32'h100, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h140, 0, 32'h140, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h104, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'hC4,  0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h84,  0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h44,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h48,  0, 0, 1, 1));
        // call+ret together
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h40, 0, 32'h40, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h80, 0, 32'h80, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h999, 1, 32'h44, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h84,  0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h4,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 1, 32'h999, 1, 32'h8, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 32'h8,   0, 0, 0, 1));
        // live redirect beats pending one
        vecs.push_back(mk(0, 0, 3'b100, 0, 0, 32'h300, 0, 0, 0, 32'h8, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b010, 0, 32'h200, 0, 0, 0, 0, 32'h200, 0, 0, 0, 1));
        // reset during stall with a pending redirect
        vecs.push_back(mk(0, 0, 3'b001, 32'h700, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 3'b001, 32'h700, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 32'h4,     0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // 8-bit address wrap
        step8(1'b1, 1'b0, 3'b000, 8'h00, 8'h00, "w8_reset");
        step8(1'b0, 1'b1, 3'b001, 8'hFC, 8'hFC, "w8_redir");
        step8(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, "w8_wrap");
        step8(1'b0, 1'b1, 3'b000, 8'h00, 8'h04, "w8_after_wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
